// File: rtl/multi_byte_add_sequencer_if.sv
// Operand/result handshake bundle for multi_byte_add_sequencer; in_sub exists only with ADDSEQ_SUB_EN.
// slave = sequencer view, master = producer/consumer view.
interface multi_byte_add_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef ADDSEQ_SUB_EN
  logic         in_sub;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;

  modport slave (
`ifdef ADDSEQ_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_cin, res_ready,
    output in_ready, res_valid, res_sum, res_cout, res_ovf
  );

  modport master (
`ifdef ADDSEQ_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_cin, res_ready,
    input  in_ready, res_valid, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/multi_byte_add_sequencer.sv
// Streams a wide add through an external 8-bit adder, LSB first, carry registered between bytes.
// Optional subtract mode under ADDSEQ_SUB_EN; result is valid NBYTES cycles after acceptance.
module multi_byte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  multi_byte_add_sequencer_if.slave    bus,
  output logic [7:0]                   add_a,
  output logic [7:0]                   add_b,
  output logic                         add_cin,
  input  logic [7:0]                   add_sum,
  input  logic                         add_cout
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [W-1:0]   b_eff;
  logic           cin_eff;
  logic [7:0]     byte_a, byte_b;

  // b_q holds the B actually presented to the adder, so overflow uses its MSB directly.
  always_comb begin
`ifdef ADDSEQ_SUB_EN
    b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
    cin_eff = bus.in_sub ? 1'b1 : bus.in_cin;
`else
    b_eff   = bus.in_b;
    cin_eff = bus.in_cin;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    add_a   = 8'd0;
    add_b   = 8'd0;
    add_cin = 1'b0;
    byte_a  = 8'd0;
    byte_b  = 8'd0;

    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = b_eff;
          carry_d = cin_eff;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = byte_a;
        add_b   = byte_b;
        add_cin = carry_q;
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) sum_d[8*i +: 8] = add_sum;
        end
        carry_d = add_cout;
        if (idx_q == IW'(NBYTES - 1)) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_ovf   = ovf_q;
endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// Directed bench for multi_byte_add_sequencer (NBYTES=4) with a behavioural 8-bit adder on the add_* ports.
module tb_multi_byte_add_sequencer;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_byte_add_sequencer_if #(.NBYTES(NB)) bus ();

  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  multi_byte_add_sequencer #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs [7];

  // Offers one operation, checks per-byte adder drive, latency and result; optionally releases it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] esum, input logic ecout,
                        input logic eovf, input bit release_res);
    logic [W-1:0] beff;
    logic         c;
    logic [8:0]   part;
    int           lat;
    beff = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
`ifdef ADDSEQ_SUB_EN
    bus.in_sub   = sub;
`endif
    bus.in_valid = 1'b1;
    chk("accept_ready", W'(bus.in_ready), W'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_cin   = ~cin;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        lat = k;
        break;
      end
      if (k < NB) begin
        chk("add_a_byte", W'(add_a), W'(a[8*k +: 8]));
        chk("add_b_byte", W'(add_b), W'(beff[8*k +: 8]));
        chk("add_cin_chain", W'(add_cin), W'(c));
        part = {1'b0, a[8*k +: 8]} + {1'b0, beff[8*k +: 8]} + {8'd0, c};
        c = part[8];
      end
    end
    chk("latency", W'(lat), W'(NB));
    chk("res_sum", bus.res_sum, esum);
    chk("res_cout", W'(bus.res_cout), W'(ecout));
    chk("res_ovf", W'(bus.res_ovf), W'(eovf));
    if (release_res) begin
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      @(negedge clk);
      chk("release_in_ready", W'(bus.in_ready), W'(1));
      chk("release_res_valid", W'(bus.res_valid), W'(0));
      chk("idle_add_a", W'(add_a), W'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
`ifdef ADDSEQ_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_res_valid", W'(bus.res_valid), W'(0));
    chk("rst_res_sum", bus.res_sum, W'(0));
    chk("rst_res_cout", W'(bus.res_cout), W'(0));
    chk("rst_res_ovf", W'(bus.res_ovf), W'(0));
    chk("rst_add_a", W'(add_a), W'(0));
    chk("rst_add_b", W'(add_b), W'(0));
    chk("rst_add_cin", W'(add_cin), W'(0));

    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].cin, 1'b0,
             vecs[v].sum, vecs[v].cout, vecs[v].ovf, 1'b1);
    end

    // Backpressure: result held while a new operand is offered and must not be taken.
    run_op(32'hA5A5_A5A5, 32'h0101_0101, 1'b0, 1'b0, 32'hA6A6_A6A6, 1'b0, 1'b0, 1'b0);
    bus.in_a     = 32'h0000_0042;
    bus.in_b     = 32'h0000_0001;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_res_valid", W'(bus.res_valid), W'(1));
      chk("hold_res_sum", bus.res_sum, 32'hA6A6_A6A6);
      chk("hold_in_ready", W'(bus.in_ready), W'(0));
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("hold_release_in_ready", W'(bus.in_ready), W'(1));
    chk("hold_release_res_valid", W'(bus.res_valid), W'(0));
    chk("hold_release_sum_kept", bus.res_sum, 32'hA6A6_A6A6);
    chk("hold_release_add_a", W'(add_a), W'(0));

    // Reset on the second RUN cycle aborts the operation.
    bus.in_a     = 32'h1234_5678;
    bus.in_b     = 32'h1111_1111;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_run", W'(bus.in_ready), W'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", W'(bus.in_ready), W'(1));
    chk("abort_res_valid", W'(bus.res_valid), W'(0));
    chk("abort_res_sum", bus.res_sum, W'(0));
    chk("abort_res_cout", W'(bus.res_cout), W'(0));
    chk("abort_add_a", W'(add_a), W'(0));
    saw_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.res_valid) saw_valid = 1'b1;
    end
    chk("abort_no_valid", W'(saw_valid), W'(0));

    // Reset and in_valid together: reset wins.
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_vs_valid_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_vs_valid_add_a", W'(add_a), W'(0));

`ifdef ADDSEQ_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    run_op(32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
